// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch/decode slice: widths, major opcodes,
// the canonical NOP encoding and the fetch state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// Two-entry FIFO of fetched {instruction, pc}; entry 0 is always the head.
module instr_queue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic [31:0]     head_instr,
  output logic [XLEN-1:0] head_pc,
  output logic [1:0]      count
);

  logic [31:0]     instr_q0, instr_q1;
  logic [XLEN-1:0] pc_q0, pc_q1;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign head_instr = instr_q0;
  assign head_pc    = pc_q0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      instr_q0 <= '0;
      instr_q1 <= '0;
      pc_q0    <= '0;
      pc_q1    <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            instr_q0 <= push_instr;
            pc_q0    <= push_pc;
          end else begin
            instr_q1 <= push_instr;
            pc_q1    <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          instr_q0 <= instr_q1;
          pc_q0    <= pc_q1;
          count    <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: the new word lands behind whatever remains.
          if (count == 2'd1) begin
            instr_q0 <= push_instr;
            pc_q0    <= push_pc;
          end else begin
            instr_q0 <= instr_q1;
            pc_q0    <= pc_q1;
            instr_q1 <= push_instr;
            pc_q1    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry instruction
// buffer, and branch redirect with wrong-path response discard.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] imm_ext
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, req_pc, target;
  logic            kill, redirect, accept, push, pop;
  logic [1:0]      count;

  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && PCSrc;
  assign target   = (instr_pc + imm_ext) & ~XLEN'(3);
  assign accept   = imem_req_valid && imem_req_ready;

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = (count != 2'd0);
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      S_REQ: begin
        // Only issue when the queue can absorb the response without a stall.
        imem_req_valid = !rst && (count < 2'd2);
        if (imem_req_valid && imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          push      = !kill && !redirect;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      kill     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (redirect) fetch_pc <= target;
      // A response arriving this cycle is dropped directly, so nothing is left to kill.
      if (state == S_WAIT && imem_rsp_valid) kill <= 1'b0;
      else if (redirect && (state == S_WAIT || accept)) kill <= 1'b1;
    end
  end

  instr_queue #(
    .XLEN(XLEN)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_instr(imem_rsp_data),
    .push_pc   (req_pc),
    .head_instr(instr),
    .head_pc   (instr_pc),
    .count     (count)
  );

endmodule
